fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_pkg.sv | 18 +
 rtl/if_id_reg.sv | 51 +++++
 rtl/fetch_stage.sv | 114 +++++++++++
 tb/tb_fetch_stage.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register; load beats bubble, bubble beats hold.
module if_id_reg
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        bubble_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        valid_o
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (load_i) begin
      pc_d    = pc_i;
      instr_d = instr_i;
      valid_d = 1'b1;
    end else if (bubble_i) begin
      pc_d    = 32'h0000_0000;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= 32'h0000_0000;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: single-outstanding imem requests, stall hold buffer,
// and jump redirect with drain of the in-flight response.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_pc_f_hazard,
  input  logic        jump,
  input  logic [31:0] jump_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_D,
  output logic [31:0] instr_D,
  output logic        valid_D
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_f_q, pc_f_d;
  logic [31:0]  hold_q, hold_d;

  logic         ifid_load;
  logic         ifid_bubble;
  logic [31:0]  ifid_instr;
  logic         accept;
  logic         stall;

  assign stall     = wb_pc_f_hazard;
  assign imem_req  = (state_q == S_FETCH) && !stall && !rst;
  assign imem_addr = pc_f_q;
  assign accept    = imem_req && imem_ready;

  always_comb begin
    state_d     = state_q;
    pc_f_d      = pc_f_q;
    hold_d      = hold_q;
    ifid_load   = 1'b0;
    ifid_bubble = !stall;
    ifid_instr  = imem_rdata;

    if (jump) begin
      // Redirect wins over stall; anything in flight must be dropped.
      ifid_bubble = 1'b1;
      pc_f_d      = align_word(jump_addr);
      case (state_q)
        S_FETCH: state_d = accept      ? S_DRAIN : S_FETCH;
        S_WAIT:  state_d = imem_rvalid ? S_FETCH : S_DRAIN;
        S_HOLD:  state_d = S_FETCH;
        S_DRAIN: state_d = imem_rvalid ? S_FETCH : S_DRAIN;
        default: state_d = S_FETCH;
      endcase
    end else begin
      case (state_q)
        S_FETCH: begin
          if (accept) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (!stall) begin
              ifid_load = 1'b1;
              pc_f_d    = pc_f_q + 32'd4;
              state_d   = S_FETCH;
            end else begin
              hold_d  = imem_rdata;
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            ifid_load  = 1'b1;
            ifid_instr = hold_q;
            pc_f_d     = pc_f_q + 32'd4;
            state_d    = S_FETCH;
          end
        end
        S_DRAIN: begin
          if (imem_rvalid) state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_f_q  <= RESET_PC;
      hold_q  <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_f_q  <= pc_f_d;
      hold_q  <= hold_d;
    end
  end

  if_id_reg u_if_id (
    .clk      (clk),
    .rst      (rst),
    .load_i   (ifid_load),
    .bubble_i (ifid_bubble),
    .pc_i     (pc_f_q),
    .instr_i  (ifid_instr),
    .pc_o     (pc_D),
    .instr_o  (instr_D),
    .valid_o  (valid_D)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Random stall/jump/reset traffic against a sequential-program reference model.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam int NCYC = 4000;

  logic        clk = 1'b0;
  logic        rst, stall, jump;
  logic [31:0] jump_addr;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] pc_D, instr_D;
  logic        valid_D;

  fetch_stage #(.RESET_PC(RPC)) dut (
    .clk            (clk),
    .rst            (rst),
    .wb_pc_f_hazard (stall),
    .jump           (jump),
    .jump_addr      (jump_addr),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .pc_D           (pc_D),
    .instr_D        (instr_D),
    .valid_D        (valid_D)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int delivered = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] pend_addr[$];
  int          pend_due[$];

  // Program image: a distinct word per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[17:2]} ^ {a[31:16], 16'h0} ^ 32'h1234_5678;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Architectural expectation: from a restart point the program runs sequentially.
  task automatic refill(input logic [31:0] base);
    exp_t e;
    logic [31:0] a;
    exp_q.delete();
    a = base;
    for (int i = 0; i < 1024; i++) begin
      e.pc    = a;
      e.instr = mem_word(a);
      exp_q.push_back(e);
      a = a + 32'd4;
    end
  endtask

  // Memory model: random ready, random latency >= 1 cycle, in-order responses.
  initial begin
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        pend_addr.delete();
        pend_due.delete();
      end
      #1;
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (pend_addr.size() > 0 && pend_due[0] <= cyc && $urandom_range(0, 2) != 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr[0]);
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      imem_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: inputs captured here are the ones applied at the next rising edge.
  logic        p_rst = 1'b1, p_jump = 1'b0, p_stall = 1'b0;
  logic [31:0] p_jaddr = 32'h0;
  logic [31:0] l_pc = 32'h0, l_instr = 32'h0;
  logic        l_valid = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (cyc > 0) begin
      if (p_rst) begin
        check("reset_valid", {31'h0, valid_D}, 32'h0);
        check("reset_instr", instr_D, NOP_INSTR);
        check("reset_pc_D", pc_D, 32'h0);
        check("reset_imem_addr", imem_addr, RPC);
      end else if (p_jump) begin
        check("jump_valid", {31'h0, valid_D}, 32'h0);
        check("jump_instr", instr_D, NOP_INSTR);
        check("jump_target", imem_addr, {p_jaddr[31:2], 2'b00});
      end else if (p_stall) begin
        check("stall_hold_valid", {31'h0, valid_D}, {31'h0, l_valid});
        check("stall_hold_pc", pc_D, l_pc);
        check("stall_hold_instr", instr_D, l_instr);
      end else if (valid_D) begin
        if (exp_q.size() == 0) begin
          check("unexpected_delivery", pc_D, 32'hDEAD_BEEF);
        end else begin
          e = exp_q.pop_front();
          check("deliver_pc", pc_D, e.pc);
          check("deliver_instr", instr_D, e.instr);
          delivered++;
        end
      end else begin
        check("bubble_instr", instr_D, NOP_INSTR);
        check("bubble_pc", pc_D, 32'h0);
      end
      if (rst) check("req_in_reset", {31'h0, imem_req}, 32'h0);
      if (imem_req) begin
        check("one_outstanding", pend_addr.size(), 0);
        if (imem_ready) begin
          pend_addr.push_back(imem_addr);
          pend_due.push_back(cyc + 1);
        end
      end
    end
    p_rst   = rst;
    p_jump  = jump;
    p_stall = stall;
    p_jaddr = jump_addr;
    l_pc    = pc_D;
    l_instr = instr_D;
    l_valid = valid_D;
  end

  // Stimulus
  initial begin
    logic        last_rst, last_jump;
    logic [31:0] last_jaddr;
    int          stall_left;
    rst        = 1'b1;
    stall      = 1'b0;
    jump       = 1'b0;
    jump_addr  = 32'h0;
    stall_left = 0;
    for (int i = 0; i < NCYC; i++) begin
      @(posedge clk);
      #2;
      last_rst   = rst;
      last_jump  = jump;
      last_jaddr = jump_addr;
      if (last_rst)       refill(RPC);
      else if (last_jump) refill({last_jaddr[31:2], 2'b00});

      rst  = (i < 3) || ($urandom_range(0, 299) == 0);
      jump = 1'b0;
      if (i >= 40) begin
        if (stall_left > 0) stall_left--;
        else if ($urandom_range(0, 5) == 0) stall_left = $urandom_range(1, 4);
        stall = (stall_left > 0);
        if ($urandom_range(0, 14) == 0) begin
          jump = 1'b1;
          if ($urandom_range(0, 3) == 0) jump_addr = 32'hFFFF_FFF0 + $urandom_range(0, 15);
          else                           jump_addr = $urandom & 32'h0000_FFFF;
        end
      end else begin
        stall = 1'b0;
      end
    end
    @(posedge clk);
    #2;
    rst = 1'b0; stall = 1'b0; jump = 1'b0;
    repeat (2) @(posedge clk);
    #7;
    check("enough_deliveries", {31'h0, delivered > 200}, 32'h1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
